reg_file_wb_arbiter: RTL and testbench

- Schedules the single register-file write port between two requesters:
  - ALU/immediate writebacks, which are single-cycle and come from the pipeline.
  - Load returns from data memory, which arrive late and are buffered in a small FIFO.
- Produces the registered write enable, address and data for the register file.
- Also produces the 2-bit write-data source code, using the same encoding as the register-file write-data controller.

---
 rtl/reg_file_wb_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_reg_file_wb_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb_arbiter
// Purpose  : Shares the single register-file write port between single-cycle
//            ALU/immediate writebacks and late load returns. Load returns are
//            buffered in a small FIFO. A two-state FSM (NORMAL / DRAIN) picks
//            which requester owns the port each cycle. The chosen write is
//            registered, so the write port sees it one cycle after the grant.
// Ports    : clock, reset_n         - clock and asynchronous active-low reset
//            i_alu_* / o_alu_ready  - ALU writeback request and its acceptance
//            i_ld_*  / o_ld_ready   - load return and FIFO space available
//            o_rf_we/waddr/wdata    - registered register-file write port
//            o_rf_wsel              - source code of the write: 00 word load,
//                                     01 byte load, 10 immediate, 11 ALU
//            o_fifo_count           - current load FIFO occupancy
// Options  : RF_WB_HAZARD_EN - when defined, an ALU write to a register that
//            has an older load still buffered is held back until that load
//            has committed.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_THRESH = 3
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         i_alu_valid,
    input  logic [1:0]                   i_alu_sel,
    input  logic [4:0]                   i_alu_rd,
    input  logic [31:0]                  i_alu_data,
    output logic                         o_alu_ready,
    input  logic                         i_ld_valid,
    input  logic                         i_ld_byte,
    input  logic [4:0]                   i_ld_rd,
    input  logic [31:0]                  i_ld_data,
    output logic                         o_ld_ready,
    output logic                         o_rf_we,
    output logic [4:0]                   o_rf_waddr,
    output logic [31:0]                  o_rf_wdata,
    output logic [1:0]                   o_rf_wsel,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_THRESH = c_CNT_W'(DRAIN_THRESH);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    localparam logic [0:0] c_ST_NORMAL = 1'b0;
    localparam logic [0:0] c_ST_DRAIN  = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [0:0]         r_state;

    logic [4:0]         r_mem_rd   [FIFO_DEPTH];
    logic [31:0]        r_mem_data [FIFO_DEPTH];
    logic               r_mem_byte [FIFO_DEPTH];

    logic               r_we;
    logic [4:0]         r_waddr;
    logic [31:0]        r_wdata;
    logic [1:0]         r_wsel;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic               w_enq;
    logic               w_deq;
    logic               w_fifo_nempty;
    logic               w_alu_block;
    logic               w_grant_alu;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [0:0]         w_state_nxt;
    logic [4:0]         w_head_rd;
    logic [31:0]        w_head_data;
    logic [1:0]         w_head_sel;

    // Ready depends on the registered count only: a full FIFO refuses a new
    // load even in a cycle where it is also popping.
    assign o_ld_ready    = (r_count < c_DEPTH);
    assign w_enq         = i_ld_valid && o_ld_ready;
    assign w_fifo_nempty = (r_count != '0);

`ifdef RF_WB_HAZARD_EN
    // An entry is live when its distance from the read pointer (modulo the
    // depth) is below the occupancy. A live entry writing the same non-zero
    // register as the ALU must commit first, so the ALU is held back.
    logic [FIFO_DEPTH-1:0] w_rd_match;

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [c_PTR_W-1:0] w_offset;
        assign w_offset       = c_PTR_W'(gi) - r_rptr;
        assign w_rd_match[gi] = ({1'b0, w_offset} < r_count) &&
                                (r_mem_rd[gi] == i_alu_rd);
    end

    assign w_alu_block = (i_alu_rd != 5'd0) && (|w_rd_match);
`else
    assign w_alu_block = 1'b0;
`endif

    assign o_alu_ready = (r_state == c_ST_NORMAL) && !w_alu_block;
    assign w_grant_alu = i_alu_valid && o_alu_ready;

    // Whenever the ALU does not take the port, the FIFO head does (if any).
    // This covers NORMAL with an idle or blocked ALU, and every DRAIN cycle.
    assign w_deq = w_fifo_nempty && !w_grant_alu;

    // Load formatting happens on the way out of the FIFO.
    assign w_head_rd   = r_mem_rd[r_rptr];
    assign w_head_data = r_mem_byte[r_rptr]
                       ? {{24{r_mem_data[r_rptr][7]}}, r_mem_data[r_rptr][7:0]}
                       : r_mem_data[r_rptr];
    assign w_head_sel  = r_mem_byte[r_rptr] ? 2'b01 : 2'b00;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // DRAIN is entered from the registered occupancy and left as soon as the
    // FIFO is empty, so the ALU is stalled only for the cycles that pop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_NORMAL: begin
                if (r_count >= c_THRESH) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_count_nxt == '0) begin
                    w_state_nxt = c_ST_NORMAL;
                end
            end
            default: w_state_nxt = c_ST_NORMAL;
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO pointers, occupancy and FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= c_ST_NORMAL;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Storage needs no reset: clearing the pointers and count discards it.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_mem_rd[r_wptr]   <= i_ld_rd;
            r_mem_data[r_wptr] <= i_ld_data;
            r_mem_byte[r_wptr] <= i_ld_byte;
        end
    end

    // ------------------------------------------------------------------------
    // Registered write port. Address, data and source follow every grant,
    // including grants to r0; only the enable is suppressed for r0.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wsel  <= 2'b00;
        end else begin
            r_we <= 1'b0;
            if (w_grant_alu) begin
                r_we    <= (i_alu_rd != 5'd0);
                r_waddr <= i_alu_rd;
                r_wdata <= i_alu_data;
                r_wsel  <= i_alu_sel;
            end else if (w_deq) begin
                r_we    <= (w_head_rd != 5'd0);
                r_waddr <= w_head_rd;
                r_wdata <= w_head_data;
                r_wsel  <= w_head_sel;
            end
        end
    end

    assign o_rf_we      = r_we;
    assign o_rf_waddr   = r_waddr;
    assign o_rf_wdata   = r_wdata;
    assign o_rf_wsel    = r_wsel;
    assign o_fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_wb_arbiter
// Purpose  : Self-checking bench for reg_file_wb_arbiter. A queue-based model
//            predicts the write port, ready signals and occupancy every cycle;
//            directed sequences pin the model to hand-computed values, then a
//            randomized run exercises arbitration, draining and resets.
// Options  : RF_WB_HAZARD_EN - must match the define used for the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb_arbiter;

    localparam int FIFO_DEPTH   = 4;
    localparam int DRAIN_THRESH = 3;

`ifdef RF_WB_HAZARD_EN
    localparam bit c_HAZ = 1'b1;
`else
    localparam bit c_HAZ = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        i_alu_valid;
    logic [1:0]  i_alu_sel;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        o_alu_ready;
    logic        i_ld_valid;
    logic        i_ld_byte;
    logic [4:0]  i_ld_rd;
    logic [31:0] i_ld_data;
    logic        o_ld_ready;
    logic        o_rf_we;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic [1:0]  o_rf_wsel;
    logic [$clog2(FIFO_DEPTH):0] o_fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_wb_arbiter #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .DRAIN_THRESH (DRAIN_THRESH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_alu_valid  (i_alu_valid),
        .i_alu_sel    (i_alu_sel),
        .i_alu_rd     (i_alu_rd),
        .i_alu_data   (i_alu_data),
        .o_alu_ready  (o_alu_ready),
        .i_ld_valid   (i_ld_valid),
        .i_ld_byte    (i_ld_byte),
        .i_ld_rd      (i_ld_rd),
        .i_ld_data    (i_ld_data),
        .o_ld_ready   (o_ld_ready),
        .o_rf_we      (o_rf_we),
        .o_rf_waddr   (o_rf_waddr),
        .o_rf_wdata   (o_rf_wdata),
        .o_rf_wsel    (o_rf_wsel),
        .o_fifo_count (o_fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the buffered loads are a plain queue, the write port is
    // whatever was granted last, and a single flag records draining.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        is_byte;
    } ld_t;

    ld_t         q[$];
    bit          m_drain;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [1:0]  e_wsel;

    initial begin
        bit  haz;
        bit  e_alu_ready;
        bit  e_ld_ready;
        bit  take_alu;
        int  old_size;
        ld_t e;
        m_drain = 1'b0;
        e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_wsel = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                q.delete();
                m_drain = 1'b0;
                e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_wsel = '0;
            end else begin
                haz = 1'b0;
`ifdef RF_WB_HAZARD_EN
                foreach (q[k]) begin
                    if (i_alu_rd != 5'd0 && q[k].rd == i_alu_rd) haz = 1'b1;
                end
`endif
                e_alu_ready = !m_drain && !haz;
                e_ld_ready  = (q.size() < FIFO_DEPTH);

                check("model_we",        32'(o_rf_we),      32'(e_we));
                check("model_waddr",     32'(o_rf_waddr),   32'(e_waddr));
                check("model_wdata",     o_rf_wdata,        e_wdata);
                check("model_wsel",      32'(o_rf_wsel),    32'(e_wsel));
                check("model_alu_ready", 32'(o_alu_ready),  32'(e_alu_ready));
                check("model_ld_ready",  32'(o_ld_ready),   32'(e_ld_ready));
                check("model_count",     32'(o_fifo_count), 32'(q.size()));

                // Outcome of the coming clock edge.
                old_size = q.size();
                take_alu = i_alu_valid && e_alu_ready;
                if (take_alu) begin
                    e_we = (i_alu_rd != 0); e_waddr = i_alu_rd;
                    e_wdata = i_alu_data;   e_wsel = i_alu_sel;
                end else if (q.size() > 0) begin
                    e = q.pop_front();
                    e_we = (e.rd != 0); e_waddr = e.rd;
                    e_wdata = e.is_byte ? 32'($signed(e.data[7:0])) : e.data;
                    e_wsel  = e.is_byte ? 2'b01 : 2'b00;
                end else begin
                    e_we = 1'b0;
                end
                if (i_ld_valid && e_ld_ready) begin
                    q.push_back('{rd: i_ld_rd, data: i_ld_data, is_byte: i_ld_byte});
                end
                if (!m_drain) m_drain = (old_size >= DRAIN_THRESH);
                else          m_drain = (q.size() != 0);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic idle();
        i_alu_valid = 1'b0;
        i_ld_valid  = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data, input logic [1:0] sel);
        i_alu_valid = 1'b1; i_alu_rd = rd; i_alu_data = data; i_alu_sel = sel;
    endtask

    task automatic drive_ld(input logic [4:0] rd, input logic [31:0] data, input logic is_byte);
        i_ld_valid = 1'b1; i_ld_rd = rd; i_ld_data = data; i_ld_byte = is_byte;
    endtask

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    initial begin
        int zeros;
        int stale;
        logic [4:0] ld_order[$];

        reset_n = 1'b0;
        i_alu_valid = 1'b0; i_alu_sel = 2'b11; i_alu_rd = '0; i_alu_data = '0;
        i_ld_valid = 1'b0; i_ld_byte = 1'b0; i_ld_rd = '0; i_ld_data = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Reset values
        @(negedge clock);
        check("rst_we",        32'(o_rf_we), 0);
        check("rst_wsel",      32'(o_rf_wsel), 0);
        check("rst_count",     32'(o_fifo_count), 0);
        check("rst_ld_ready",  32'(o_ld_ready), 1);
        check("rst_alu_ready", 32'(o_alu_ready), 1);

        // Plain ALU write
        cyc(); drive_alu(5'd5, 32'h0000_1234, 2'b11);
        @(negedge clock); check("alu_ready", 32'(o_alu_ready), 1);
        cyc(); idle();
        @(negedge clock);
        check("alu_we",    32'(o_rf_we), 1);
        check("alu_waddr", 32'(o_rf_waddr), 5);
        check("alu_wdata", o_rf_wdata, 32'h0000_1234);
        check("alu_wsel",  32'(o_rf_wsel), 3);

        // Byte load, sign-extended, two cycles after it is presented
        cyc(); drive_ld(5'd7, 32'h0000_0080, 1'b1);
        cyc(); idle();
        @(negedge clock);
        check("bl_pending_we", 32'(o_rf_we), 0);
        check("bl_count",      32'(o_fifo_count), 1);
        cyc();
        @(negedge clock);
        check("bl_we",    32'(o_rf_we), 1);
        check("bl_waddr", 32'(o_rf_waddr), 7);
        check("bl_wdata", o_rf_wdata, 32'hFFFF_FF80);
        check("bl_wsel",  32'(o_rf_wsel), 1);

        // Three loads behind a busy ALU trigger a drain
        for (int i = 0; i < 3; i++) begin
            cyc(); drive_alu(5'd1, 32'h1111_0000 + i, 2'b11); drive_ld(5'(10 + i), 32'hA000_0000 + i, 1'b0);
        end
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(); i_ld_valid = 1'b0;
            @(negedge clock);
            if (o_alu_ready == 1'b0) zeros++;
            if (o_rf_we && o_rf_wsel == 2'b00) ld_order.push_back(o_rf_waddr);
        end
        check("drain_stall_cycles", zeros, 3);
        check("drain_n_loads", ld_order.size(), 3);
        for (int i = 0; i < 3 && i < ld_order.size(); i++) begin
            check("drain_order", 32'(ld_order[i]), 10 + i);
        end
        check("drain_ready_back", 32'(o_alu_ready), 1);
        check("drain_count_zero", 32'(o_fifo_count), 0);

        // Fill to capacity
        for (int i = 0; i < 4; i++) begin
            cyc(); drive_alu(5'd2, 32'h2222_0000 + i, 2'b10); drive_ld(5'(20 + i), 32'hB000_0000 + i, 1'b0);
        end
        cyc(); idle();
        @(negedge clock);
        check("full_count",     32'(o_fifo_count), 4);
        check("full_ld_ready",  32'(o_ld_ready), 0);
        check("full_alu_ready", 32'(o_alu_ready), 0);
        repeat (8) cyc();

        // r0 suppression for both requesters
        cyc(); drive_alu(5'd0, 32'h0000_DEAD, 2'b11);
        @(negedge clock); check("r0_alu_ready", 32'(o_alu_ready), 1);
        cyc(); idle();
        @(negedge clock);
        check("r0_alu_we",    32'(o_rf_we), 0);
        check("r0_alu_waddr", 32'(o_rf_waddr), 0);
        check("r0_alu_wdata", o_rf_wdata, 32'h0000_DEAD);
        cyc(); drive_ld(5'd0, 32'h0000_0055, 1'b0);
        cyc(); idle();
        @(negedge clock); check("r0_ld_count1", 32'(o_fifo_count), 1);
        cyc();
        @(negedge clock);
        check("r0_ld_count0", 32'(o_fifo_count), 0);
        check("r0_ld_we",     32'(o_rf_we), 0);
        check("r0_ld_wdata",  o_rf_wdata, 32'h0000_0055);
        check("r0_ld_wsel",   32'(o_rf_wsel), 0);

        // Same-destination ordering between a buffered load and the ALU
        cyc(); drive_ld(5'd9, 32'h0000_AAAA, 1'b0);
        cyc(); i_ld_valid = 1'b0; drive_alu(5'd9, 32'h0000_BBBB, 2'b11);
        @(negedge clock); check("haz_alu_ready", 32'(o_alu_ready), c_HAZ ? 0 : 1);
        cyc(); if (!c_HAZ) i_alu_valid = 1'b0;
        @(negedge clock);
        check("haz_first_we",    32'(o_rf_we), 1);
        check("haz_first_wdata", o_rf_wdata, c_HAZ ? 32'h0000_AAAA : 32'h0000_BBBB);
        check("haz_first_wsel",  32'(o_rf_wsel), c_HAZ ? 0 : 3);
        cyc(); idle();
        @(negedge clock);
        check("haz_second_we",    32'(o_rf_we), 1);
        check("haz_second_waddr", 32'(o_rf_waddr), 9);
        check("haz_second_wdata", o_rf_wdata, c_HAZ ? 32'h0000_BBBB : 32'h0000_AAAA);

        // Reset while two loads are buffered
        for (int i = 0; i < 2; i++) begin
            cyc(); drive_alu(5'd3, 32'h0000_0077, 2'b11); drive_ld(5'(14 + i), 32'hC000_0000 + i, 1'b0);
        end
        cyc(); i_ld_valid = 1'b0;
        @(negedge clock);
        check("prerst_we",    32'(o_rf_we), 1);
        check("prerst_count", 32'(o_fifo_count), 2);
        @(posedge clock); #3 reset_n = 1'b0;
        #1;
        check("midrst_we",    32'(o_rf_we), 0);
        check("midrst_count", 32'(o_fifo_count), 0);
        check("midrst_wdata", o_rf_wdata, 0);
        cyc(); reset_n = 1'b1; idle();
        stale = 0;
        repeat (5) begin
            @(negedge clock);
            if (o_rf_we) stale++;
        end
        check("postrst_stale_writes", stale, 0);

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 2000; n++) begin
            cyc();
            i_alu_valid = ($urandom_range(0, 99) < 50);
            i_alu_rd    = 5'($urandom_range(0, 7));
            i_alu_sel   = $urandom_range(0, 1) ? 2'b11 : 2'b10;
            i_alu_data  = $urandom;
            i_ld_valid  = ($urandom_range(0, 99) < 45);
            i_ld_rd     = 5'($urandom_range(0, 7));
            i_ld_byte   = 1'($urandom_range(0, 1));
            i_ld_data   = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                #2 reset_n = 1'b0;
                cyc(); reset_n = 1'b1;
            end
        end
        cyc(); idle();
        repeat (10) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
